mul_div_unit: RTL and testbench

- HI/LO multiply-divide unit in the E stage, directly downstream of the instruction decoder.
- Consumes the decoder's ALUop codes for mult, multu, div, divu, mthi and mtlo, plus the E-stage rs/rt operands.
- Models the multi-cycle latency of multiply and divide, and exposes busy for the hazard unit's md/mf/mt stall logic.
- Drives HI/LO to the M-stage write-back mux for mfhi/mflo.

---
 rtl/mul_div_unit_if.sv | 32 +++
 rtl/mul_div_unit.sv | 137 +++++++++++++
 tb/tb_mul_div_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// HI/LO multiply-divide unit bus: E-stage request, operands and HI/LO/busy results.
interface mul_div_unit_if;
   logic        start;
   logic [7:0]  ALUop;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   // Decoder/E-stage side drives requests and reads results.
   modport master (
      output start,
      output ALUop,
      output A,
      output B,
      input  busy,
      input  HI,
      input  LO
   );

   // Multiply-divide unit side.
   modport slave (
      input  start,
      input  ALUop,
      input  A,
      input  B,
      output busy,
      output HI,
      output LO
   );
endinterface

// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit: multi-cycle mult/multu/div/divu plus mthi/mtlo.
// Results are computed from the latched operands and committed when the
// down-counter expires; busy, HI and LO are all registered.
module mul_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic         clk,
   input logic         reset,
   mul_div_unit_if.slave md
);

   localparam logic [7:0] OpMult  = 8'd24;
   localparam logic [7:0] OpMultu = 8'd25;
   localparam logic [7:0] OpDiv   = 8'd26;
   localparam logic [7:0] OpDivu  = 8'd27;
   localparam logic [7:0] OpMthi  = 8'd28;
   localparam logic [7:0] OpMtlo  = 8'd29;

   localparam logic [4:0] MultCnt = 5'(MULT_CYCLES);
   localparam logic [4:0] DivCnt  = 5'(DIV_CYCLES);

   logic [4:0]  cnt_q;
   logic        busy_q;
   logic [7:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic [63:0] prod;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] divisor;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_we;

   // Result of the latched operation; only committed when the counter expires.
   always_comb begin
      prod    = 64'd0;
      mag_a   = a_q;
      mag_b   = b_q;
      divisor = 32'd1;
      q_mag   = 32'd0;
      r_mag   = 32'd0;
      res_hi  = hi_q;
      res_lo  = lo_q;
      res_we  = 1'b0;
      case (op_q)
         OpMult: begin
            // Sign-extend to 64 bits; the low 64 bits of the product are exact.
            prod   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            res_we = 1'b1;
         end
         OpMultu: begin
            prod   = {32'd0, a_q} * {32'd0, b_q};
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            res_we = 1'b1;
         end
         OpDiv: begin
            // Divide magnitudes, then fix signs; 0x80000000/-1 wraps to 0x80000000.
            mag_a   = a_q[31] ? -a_q : a_q;
            mag_b   = b_q[31] ? -b_q : b_q;
            divisor = (b_q == 32'd0) ? 32'd1 : mag_b;
            q_mag   = mag_a / divisor;
            r_mag   = mag_a % divisor;
            res_lo  = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
            res_hi  = a_q[31] ? -r_mag : r_mag;
            res_we  = (b_q != 32'd0);
         end
         OpDivu: begin
            divisor = (b_q == 32'd0) ? 32'd1 : b_q;
            res_lo  = a_q / divisor;
            res_hi  = a_q % divisor;
            res_we  = (b_q != 32'd0);
         end
         default: begin
            res_we = 1'b0;
         end
      endcase
   end

   // Accept, countdown and HI/LO commit; requests while busy are dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q  <= 5'd0;
         busy_q <= 1'b0;
         op_q   <= 8'd0;
         a_q    <= 32'd0;
         b_q    <= 32'd0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
      end else if (cnt_q == 5'd0) begin
         if (md.start) begin
            case (md.ALUop)
               OpMult, OpMultu: begin
                  op_q   <= md.ALUop;
                  a_q    <= md.A;
                  b_q    <= md.B;
                  cnt_q  <= MultCnt;
                  busy_q <= 1'b1;
               end
               OpDiv, OpDivu: begin
                  op_q   <= md.ALUop;
                  a_q    <= md.A;
                  b_q    <= md.B;
                  cnt_q  <= DivCnt;
                  busy_q <= 1'b1;
               end
               OpMthi:  hi_q <= md.A;
               OpMtlo:  lo_q <= md.A;
               default: ;
            endcase
         end
      end else if (cnt_q == 5'd1) begin
         cnt_q  <= 5'd0;
         busy_q <= 1'b0;
         if (res_we) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end
      end else begin
         cnt_q <= cnt_q - 5'd1;
      end
   end

   assign md.busy = busy_q;
   assign md.HI   = hi_q;
   assign md.LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops
// against a plain-arithmetic HI/LO reference model.
module tb_mul_div_unit;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   logic [31:0] hi_m;
   logic [31:0] lo_m;

   mul_div_unit_if mdif ();

   mul_div_unit #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .md    (mdif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: what HI/LO become after op completes.
   task automatic model_apply(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sp;
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] up;
      case (op)
         8'd24: begin
            sp   = longint'($signed(a)) * longint'($signed(b));
            hi_m = sp[63:32];
            lo_m = sp[31:0];
         end
         8'd25: begin
            up   = {32'd0, a} * {32'd0, b};
            hi_m = up[63:32];
            lo_m = up[31:0];
         end
         8'd26: begin
            if (b != 32'd0) begin
               sa   = longint'($signed(a));
               sb   = longint'($signed(b));
               q    = sa / sb;
               r    = sa % sb;
               lo_m = q[31:0];
               hi_m = r[31:0];
            end
         end
         8'd27: begin
            if (b != 32'd0) begin
               lo_m = a / b;
               hi_m = a % b;
            end
         end
         8'd28:   hi_m = a;
         8'd29:   lo_m = a;
         default: ;
      endcase
   endtask

   // Issue a multi-cycle op, measure busy, optionally poke the bus mid-flight.
   task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb, input string tag);
      int n;
      int exp_n;
      exp_n = (op == 8'd24 || op == 8'd25) ? 5 : 10;
      mdif.start = 1'b1;
      mdif.ALUop = op;
      mdif.A     = a;
      mdif.B     = b;
      step();
      mdif.start = 1'b0;
      mdif.A     = $urandom;
      mdif.B     = $urandom;
      n = 0;
      while (mdif.busy && n < 40) begin
         if (disturb && n == 2) begin
            mdif.start = 1'b1;
            mdif.ALUop = 8'd28;
            mdif.A     = 32'hDEAD;
            mdif.B     = $urandom;
         end else begin
            mdif.start = 1'b0;
            mdif.A     = $urandom;
         end
         n++;
         step();
      end
      mdif.start = 1'b0;
      model_apply(op, a, b);
      check({tag, " busy_len"}, 32'(n), 32'(exp_n));
      check({tag, " HI"}, mdif.HI, hi_m);
      check({tag, " LO"}, mdif.LO, lo_m);
   endtask

   // Single-edge op (mthi/mtlo/no-op): never raises busy.
   task automatic run_move(input logic [7:0] op, input logic [31:0] a, input string tag);
      mdif.start = 1'b1;
      mdif.ALUop = op;
      mdif.A     = a;
      mdif.B     = $urandom;
      step();
      mdif.start = 1'b0;
      model_apply(op, a, 32'd0);
      check({tag, " busy"}, {31'd0, mdif.busy}, 32'd0);
      check({tag, " HI"}, mdif.HI, hi_m);
      check({tag, " LO"}, mdif.LO, lo_m);
   endtask

   initial begin
      logic [7:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      total      = 0;
      bad        = 0;
      hi_m       = 32'd0;
      lo_m       = 32'd0;
      reset      = 1'b0;
      mdif.start = 1'b0;
      mdif.ALUop = 8'd0;
      mdif.A     = 32'd0;
      mdif.B     = 32'd0;
      step();
      step();
      check("reset busy", {31'd0, mdif.busy}, 32'd0);
      check("reset HI", mdif.HI, 32'd0);
      check("reset LO", mdif.LO, 32'd0);
      reset = 1'b1;

      run_op(8'd24, 32'd3, 32'hFFFFFFFE, 1'b0, "mult");
      check("mult const HI", mdif.HI, 32'hFFFFFFFF);
      check("mult const LO", mdif.LO, 32'hFFFFFFFA);
      run_op(8'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu");
      check("multu const HI", mdif.HI, 32'hFFFFFFFE);
      check("multu const LO", mdif.LO, 32'h00000001);
      run_op(8'd24, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mult m1");
      check("mult m1 const HI", mdif.HI, 32'h0);
      check("mult m1 const LO", mdif.LO, 32'h1);

      run_op(8'd26, 32'hFFFFFFF9, 32'd2, 1'b0, "div");
      check("div const LO", mdif.LO, 32'hFFFFFFFD);
      check("div const HI", mdif.HI, 32'hFFFFFFFF);
      run_op(8'd27, 32'hFFFFFFF9, 32'd2, 1'b0, "divu");
      check("divu const LO", mdif.LO, 32'h7FFFFFFC);
      check("divu const HI", mdif.HI, 32'h1);
      run_op(8'd26, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div ovf");
      check("div ovf const LO", mdif.LO, 32'h80000000);
      check("div ovf const HI", mdif.HI, 32'h0);

      run_move(8'd28, 32'h1234, "mthi");
      run_move(8'd29, 32'h5678, "mtlo");
      run_op(8'd26, 32'd9, 32'd0, 1'b0, "div0");
      check("div0 const HI", mdif.HI, 32'h1234);
      check("div0 const LO", mdif.LO, 32'h5678);
      run_op(8'd27, 32'd9, 32'd0, 1'b0, "divu0");

      // mthi during busy must be dropped and operands must stay latched.
      run_op(8'd26, 32'd100, 32'd7, 1'b1, "busy start");
      check("busy start const LO", mdif.LO, 32'd14);
      check("busy start const HI", mdif.HI, 32'd2);

      run_move(8'd0, 32'hCAFE, "noop");
      run_move(8'd30, 32'hBEEF, "noop30");

      // Reset on the 4th busy cycle of a mult.
      mdif.start = 1'b1;
      mdif.ALUop = 8'd24;
      mdif.A     = 32'd1000;
      mdif.B     = 32'd1000;
      step();
      mdif.start = 1'b0;
      step();
      step();
      step();
      check("mid busy", {31'd0, mdif.busy}, 32'd1);
      reset = 1'b0;
      step();
      hi_m = 32'd0;
      lo_m = 32'd0;
      check("mid reset busy", {31'd0, mdif.busy}, 32'd0);
      check("mid reset HI", mdif.HI, 32'd0);
      check("mid reset LO", mdif.LO, 32'd0);
      reset = 1'b1;
      run_op(8'd25, 32'd6, 32'd7, 1'b0, "post reset");

      for (int i = 0; i < 40; i++) begin
         rop = 8'($urandom_range(23, 30));
         ra  = $urandom;
         rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) begin
            ra = 32'($urandom_range(0, 50)) - 32'd25;
            rb = 32'($urandom_range(0, 10)) - 32'd5;
         end
         if (rop >= 8'd24 && rop <= 8'd27) begin
            run_op(rop, ra, rb, bit'($urandom_range(0, 1)), "rand op");
         end else begin
            run_move(rop, ra, "rand move");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
